// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU image datapath.
// Covers the image RAM geometry and the port A arbiter encodings.
package npu_pkg;

    localparam int RAM_ADDR_W  = 19;
    localparam int RAM_DATA_W  = 8;

    localparam int IMG_BASE    = 0;
    localparam int RESULT_BASE = 160000;
    localparam int IMG_W       = 400;

    typedef enum logic [1:0] {
        ARB,
        LOCK0,
        LOCK1
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_0    = 2'd1;
    localparam logic [1:0] OWNER_1    = 2'd2;

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-way round-robin arbiter for image RAM port A.
// Requester 0 is the host loader; requester 1 is the NPU tile sequencer.
module ram_port_arbiter
    import npu_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_0,
    input  logic              we_0,
    input  logic              lock_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              rvalid_0,

    input  logic              req_1,
    input  logic              we_1,
    input  logic              lock_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic [1:0]        owner
);

    arb_state_t state;
    logic       last_gnt;   // 1 = requester 1 was granted most recently
    logic       tag_valid;
    logic       tag_id;
    logic       pick_0;
    logic       pick_1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pick_0 = 1'b0;
        pick_1 = 1'b0;
        case (state)
            LOCK0:   pick_0 = 1'b1;
            LOCK1:   pick_1 = 1'b1;
            default: begin
                pick_0 = !req_1 || last_gnt;
                pick_1 = !req_0 || !last_gnt;
            end
        endcase
    end

    assign gnt_0 = req_0 & pick_0;
    assign gnt_1 = req_1 & pick_1;
    assign rdata = ram_rdata;

    // NOTE: sequential state uses non-blocking assignments only; the defaults at the
    // top of the else branch are overridden by later assignments in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            last_gnt  <= 1'b1;
            tag_valid <= 1'b0;
            tag_id    <= 1'b0;
            rvalid_0  <= 1'b0;
            rvalid_1  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            owner     <= OWNER_NONE;
        end else begin
            rvalid_0  <= tag_valid & !tag_id;
            rvalid_1  <= tag_valid & tag_id;
            ram_wren  <= 1'b0;
            tag_valid <= 1'b0;

            if (gnt_0) begin
                ram_addr  <= addr_0;
                ram_wdata <= wdata_0;
                ram_wren  <= we_0;
                last_gnt  <= 1'b0;
                tag_valid <= !we_0;
                tag_id    <= 1'b0;
                state     <= lock_0 ? LOCK0 : ARB;
                owner     <= lock_0 ? OWNER_0 : OWNER_NONE;
            end else if (gnt_1) begin
                ram_addr  <= addr_1;
                ram_wdata <= wdata_1;
                ram_wren  <= we_1;
                last_gnt  <= 1'b1;
                tag_valid <= !we_1;
                tag_id    <= 1'b1;
                state     <= lock_1 ? LOCK1 : ARB;
                owner     <= lock_1 ? OWNER_1 : OWNER_NONE;
            end else if ((state == LOCK0 && !req_0) || (state == LOCK1 && !req_1)) begin
                // Owner walked away mid-burst: release the port.
                state <= ARB;
                owner <= OWNER_NONE;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a registered-read RAM model on port A.
module tb_ram_port_arbiter;
    import npu_pkg::*;

    localparam int AW = RAM_ADDR_W;
    localparam int DW = RAM_DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_0, we_0, lock_0, gnt_0, rvalid_0;
    logic          req_1, we_1, lock_1, gnt_1, rvalid_1;
    logic [AW-1:0] addr_0, addr_1, ram_addr;
    logic [DW-1:0] wdata_0, wdata_1, ram_wdata, ram_rdata, rdata;
    logic          ram_wren;
    logic [1:0]    owner;

    int n_checks = 0;
    int n_pass   = 0;

    always #20 clk = ~clk;

    ram_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_0     (req_0),
        .we_0      (we_0),
        .lock_0    (lock_0),
        .addr_0    (addr_0),
        .wdata_0   (wdata_0),
        .gnt_0     (gnt_0),
        .rvalid_0  (rvalid_0),
        .req_1     (req_1),
        .we_1      (we_1),
        .lock_1    (lock_1),
        .addr_1    (addr_1),
        .wdata_1   (wdata_1),
        .gnt_1     (gnt_1),
        .rvalid_1  (rvalid_1),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wren  (ram_wren),
        .ram_rdata (ram_rdata),
        .owner     (owner)
    );

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [7:0] pat(input int a);
        return 8'((a * 7) + 3);
    endfunction

    logic [7:0] mem [int];

    always @(posedge clk) begin
        if (mem.exists(int'(ram_addr))) ram_rdata <= mem[int'(ram_addr)];
        else                            ram_rdata <= pat(int'(ram_addr));
        if (ram_wren) mem[int'(ram_addr)] = ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req_0 = 0; we_0 = 0; lock_0 = 0; addr_0 = '0; wdata_0 = '0;
        req_1 = 0; we_1 = 0; lock_1 = 0; addr_1 = '0; wdata_1 = '0;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #2;
        check("rst_ram_addr",  32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        check("rst_ram_wren",  32'(ram_wren), 0);
        check("rst_rvalid",    32'({rvalid_0, rvalid_1}), 0);
        check("rst_owner",     32'(owner), 0);
        rst = 1'b0;

        // Idle: nothing moves for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            check("idle_outs", 32'({gnt_0, gnt_1, ram_wren, rvalid_0, rvalid_1, owner}), 0);
        end

        // Tie after reset: requester 0 wins first.
        tick();
        req_0 = 1; addr_0 = 19'd100; req_1 = 1; addr_1 = 19'd200;
        #1;
        check("tie_c0_gnt", 32'({gnt_0, gnt_1}), 32'b10);
        tick();
        req_0 = 0;
        #1;
        check("tie_c1_gnt",   32'({gnt_0, gnt_1}), 32'b01);
        check("tie_c1_addr",  32'(ram_addr), 100);
        check("tie_c1_rv0",   32'(rvalid_0), 0);
        tick();
        req_1 = 0;
        #1;
        check("tie_c2_rv",    32'({rvalid_0, rvalid_1}), 32'b10);
        check("tie_c2_rdata", 32'(rdata), 32'(pat(100)));
        check("tie_c2_addr",  32'(ram_addr), 200);
        tick();
        #1;
        check("tie_c3_rv",    32'({rvalid_0, rvalid_1}), 32'b01);
        check("tie_c3_rdata", 32'(rdata), 32'(pat(200)));
        tick();
        #1;
        check("tie_c4_rv",    32'({rvalid_0, rvalid_1}), 0);

        // Write 0xA5 then read it back on the next cycle.
        tick();
        req_1 = 1; we_1 = 1; addr_1 = AW'(RESULT_BASE); wdata_1 = 8'hA5;
        #1;
        check("wr_c0_gnt1", 32'(gnt_1), 1);
        check("wr_c0_wren", 32'(ram_wren), 0);
        tick();
        we_1 = 0;
        #1;
        check("rd_c1_gnt1",  32'(gnt_1), 1);
        check("wr_c1_wren",  32'(ram_wren), 1);
        check("wr_c1_addr",  32'(ram_addr), RESULT_BASE);
        check("wr_c1_wdata", 32'(ram_wdata), 32'hA5);
        tick();
        req_1 = 0;
        #1;
        check("rd_c2_wren",  32'(ram_wren), 0);
        check("rd_c2_rv1",   32'(rvalid_1), 0);
        check("rd_c2_addr",  32'(ram_addr), RESULT_BASE);
        tick();
        #1;
        check("rd_c3_rv1",   32'(rvalid_1), 1);
        check("rd_c3_rdata", 32'(rdata), 32'hA5);

        // Locked 100-read burst by requester 1 while requester 0 waits.
        base = RESULT_BASE + 1000;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) begin
                req_1 = 1; we_1 = 0;
            end
            if (i == 1) begin
                req_0 = 1; we_0 = 0; addr_0 = 19'd5;
            end
            addr_1 = AW'(base + i);
            lock_1 = (i != 99);
            #1;
            check("burst_gnt1", 32'(gnt_1), 1);
            check("burst_gnt0", 32'(gnt_0), 0);
            if (i >= 1) check("burst_owner", 32'(owner), 2);
            if (i >= 2) begin
                check("burst_rv1",   32'(rvalid_1), 1);
                check("burst_rdata", 32'(rdata), 32'(pat(base + i - 2)));
            end
        end
        tick();
        req_1 = 0; lock_1 = 0;
        #1;
        check("post_burst_gnt0",  32'({gnt_0, gnt_1}), 32'b10);
        check("post_burst_owner", 32'(owner), 0);
        check("post_burst_rv1",   32'(rvalid_1), 1);
        check("post_burst_rd98",  32'(rdata), 32'(pat(base + 98)));
        tick();
        req_0 = 0;
        #1;
        check("post_burst_rv",    32'({rvalid_0, rvalid_1}), 32'b01);
        check("post_burst_rd99",  32'(rdata), 32'(pat(base + 99)));
        tick();
        #1;
        check("post_burst_rv0",   32'({rvalid_0, rvalid_1}), 32'b10);
        check("post_burst_rd0",   32'(rdata), 32'(pat(5)));

        // Lock abandonment by requester 0.
        tick();
        req_0 = 1; lock_0 = 1; addr_0 = 19'd7;
        #1;
        check("abn_c0_gnt0", 32'(gnt_0), 1);
        tick();
        req_0 = 0; lock_0 = 0; req_1 = 1; addr_1 = 19'd9;
        #1;
        check("abn_c1_gnt1",  32'(gnt_1), 0);
        check("abn_c1_owner", 32'(owner), 1);
        tick();
        #1;
        check("abn_c2_owner", 32'(owner), 0);
        check("abn_c2_gnt1",  32'(gnt_1), 1);
        check("abn_c2_rv0",   32'(rvalid_0), 1);
        check("abn_c2_rdata", 32'(rdata), 32'(pat(7)));
        tick();
        req_1 = 0;
        tick();
        #1;
        check("abn_c4_rv1",   32'(rvalid_1), 1);
        check("abn_c4_rdata", 32'(rdata), 32'(pat(9)));

        // Reset in c1 of a locked read by requester 0.
        tick();
        req_0 = 1; lock_0 = 1; addr_0 = 19'd11;
        #1;
        check("rst_c0_gnt0", 32'(gnt_0), 1);
        tick();
        req_0 = 0; lock_0 = 0; rst = 1'b1;
        #1;
        check("midrst_addr",  32'(ram_addr), 0);
        check("midrst_owner", 32'(owner), 0);
        check("midrst_wren",  32'(ram_wren), 0);
        check("midrst_rv",    32'({rvalid_0, rvalid_1}), 0);
        tick();
        #1;
        check("midrst_c2_rv", 32'({rvalid_0, rvalid_1, ram_wren}), 0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_rel_rv", 32'({rvalid_0, rvalid_1, ram_wren}), 0);
        tick();
        req_0 = 1; addr_0 = 19'd20; req_1 = 1; addr_1 = 19'd30;
        #1;
        check("postrst_tie", 32'({gnt_0, gnt_1}), 32'b10);
        tick();
        req_0 = 0;
        #1;
        check("postrst_gnt1", 32'({gnt_0, gnt_1}), 32'b01);
        tick();
        req_1 = 0;
        #1;
        check("postrst_rv0",    32'({rvalid_0, rvalid_1}), 32'b10);
        check("postrst_rdata0", 32'(rdata), 32'(pat(20)));
        tick();
        #1;
        check("postrst_rv1",    32'({rvalid_0, rvalid_1}), 32'b01);
        check("postrst_rdata1", 32'(rdata), 32'(pat(30)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
